// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy counters need one extra bit so that a completely full FIFO is representable.
  function automatic int level_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple-dual-port RAM, one write port and one registered read port.
// Read-during-write to the same address returns the old contents.
module fifo_ram_sdp #(
  parameter int AW = 5,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_q;

  // Array write and registered read; the read register holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with occupancy level, programmable almost-full/almost-empty,
// synchronous flush and a build-time choice of FWFT or registered read.
// In FWFT mode a 2-entry prefetch stage sits behind the RAM read register so
// pops can run back to back; in registered mode the RAM is read on the pop.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int ADDRWIDTH = 5,
  parameter int DATAWIDTH = 18,
  parameter int SLOP      = 4,
  parameter int FWFT      = FIFO_MODE_FWFT
) (
  input  logic                          clk,
  input  logic                          reset_l,
  input  logic                          clr,
  input  logic [DATAWIDTH-1:0]          wr_data,
  input  logic                          we,
  output logic                          full,
  output logic                          almost_full,
  output logic                          ovf,
  output logic [DATAWIDTH-1:0]          rd_data,
  input  logic                          re,
  output logic                          ne,
  output logic                          almost_empty,
  output logic                          unf,
  output logic [level_w(ADDRWIDTH)-1:0] level,
  input  logic [level_w(ADDRWIDTH)-1:0] af_thresh,
  input  logic [level_w(ADDRWIDTH)-1:0] ae_thresh
);

  localparam int            LW      = level_w(ADDRWIDTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(1 << ADDRWIDTH);
  localparam logic [LW-1:0] FULL_L  = LW'((1 << ADDRWIDTH) - SLOP);

  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d, ram_cnt_q, ram_cnt_d;
  logic                 ram_vld_q, ram_vld_d, rd_vld_q, rd_vld_d;
  logic [1:0]           pf_cnt_q, pf_cnt_d, pf_left;
  logic [DATAWIDTH-1:0] pf0_q, pf0_d, pf1_q, pf1_d, rd_q, rd_d, ram_dout;
  logic                 ne_q, ne_d, full_q, full_d, af_q, af_d, ae_q, ae_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic                 pop, wr_acc, ram_we, ram_re, xfer;

  fifo_ram_sdp #(
    .AW (ADDRWIDTH),
    .DW (DATAWIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_dout)
  );

  // Handshake decode: accepted write, valid pop, RAM read issue and RAM-to-prefetch transfer.
  always_comb begin
    pop     = re && ne_q;
    wr_acc  = we && ((level_q != DEPTH_L) || pop);
    ram_we  = wr_acc && reset_l && !clr;
    pf_left = pf_cnt_q - {1'b0, pop};
    xfer    = 1'b0;
    ram_re  = 1'b0;
    if (FWFT == FIFO_MODE_FWFT) begin
      // Only refill the RAM read register when its current word leaves or it is empty.
      xfer   = ram_vld_q && (pf_left != 2'd2);
      ram_re = (ram_cnt_q != '0) && (!ram_vld_q || xfer);
    end else begin
      ram_re = pop;
    end
  end

  // Next-state for pointers, counters, prefetch/output data and registered flags.
  always_comb begin
    wr_ptr_d  = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = ram_re ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_cnt_d = ram_cnt_q + LW'(wr_acc) - LW'(ram_re);
    level_d   = level_q + LW'(wr_acc) - LW'(pop);
    ram_vld_d = ram_re ? 1'b1 : (xfer ? 1'b0 : ram_vld_q);

    pf0_d = pop ? pf1_q : pf0_q;
    pf1_d = pf1_q;
    if (xfer) begin
      if (pf_left == 2'd0) pf0_d = ram_dout;
      else                 pf1_d = ram_dout;
    end
    pf_cnt_d = pf_left + {1'b0, xfer};

    rd_vld_d = (FWFT == FIFO_MODE_REG) && ram_re;
    rd_d     = rd_vld_q ? ram_dout : rd_q;

    // In FWFT a word loaded this cycle only becomes poppable after the next edge.
    ne_d   = (FWFT == FIFO_MODE_FWFT) ? (pf_left != 2'd0) : (level_d != '0);
    full_d = level_d >= FULL_L;
    af_d   = level_d >= af_thresh;
    ae_d   = level_d <= ae_thresh;
    ovf_d  = ovf_q || (we && !wr_acc);
    unf_d  = unf_q || (re && !ne_q);
  end

  // State register; reset and flush both return the FIFO to empty.
  always_ff @(posedge clk) begin
    if (!reset_l || clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      level_q   <= '0;
      ram_vld_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      pf_cnt_q  <= '0;
      pf0_q     <= '0;
      pf1_q     <= '0;
      rd_q      <= '0;
      ne_q      <= 1'b0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      level_q   <= level_d;
      ram_vld_q <= ram_vld_d;
      rd_vld_q  <= rd_vld_d;
      pf_cnt_q  <= pf_cnt_d;
      pf0_q     <= pf0_d;
      pf1_q     <= pf1_d;
      rd_q      <= rd_d;
      ne_q      <= ne_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign rd_data      = (FWFT == FIFO_MODE_FWFT) ? pf0_q : rd_q;
  assign ne           = ne_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign ovf          = ovf_q;
  assign unf          = unf_q;
  assign level        = level_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: one FWFT and one registered-read instance on shared inputs.
module tb_fifo_sync_prog;

  logic        clk = 1'b0;
  logic        reset_l, clr, we, re;
  logic [17:0] wr_data;
  logic [5:0]  af_thresh, ae_thresh;

  logic        full_f, af_f, ovf_f, ne_f, ae_f, unf_f;
  logic [17:0] rd_f;
  logic [5:0]  level_f;
  logic        full_r, af_r, ovf_r, ne_r, ae_r, unf_r;
  logic [17:0] rd_r;
  logic [5:0]  level_r;

  int errors = 0;
  int checks = 0;
  int rcnt;
  bit started;

  always #5 clk = ~clk;

  fifo_sync_prog #(.ADDRWIDTH(5), .DATAWIDTH(18), .SLOP(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset_l(reset_l), .clr(clr), .wr_data(wr_data), .we(we),
    .full(full_f), .almost_full(af_f), .ovf(ovf_f), .rd_data(rd_f), .re(re),
    .ne(ne_f), .almost_empty(ae_f), .unf(unf_f), .level(level_f),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh));

  fifo_sync_prog #(.ADDRWIDTH(5), .DATAWIDTH(18), .SLOP(4), .FWFT(0)) u_reg (
    .clk(clk), .reset_l(reset_l), .clr(clr), .wr_data(wr_data), .we(we),
    .full(full_r), .almost_full(af_r), .ovf(ovf_r), .rd_data(rd_r), .re(re),
    .ne(ne_r), .almost_empty(ae_r), .unf(unf_r), .level(level_r),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh));

  typedef struct {
    logic        we;
    logic        re;
    logic [17:0] d;
    int          lvl;
    logic        ne;
    logic        ae;
    logic        af;
    logic        unf;
    logic [17:0] rd;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    clr = 1'b0; we = 1'b0; re = 1'b0;
    step();
    step();
    reset_l = 1'b1;
  endtask

  initial begin
    wr_data = '0;
    af_thresh = 6'd20;
    ae_thresh = 6'd3;
    do_reset();

    // Reset state on both instances
    chk("rst_level_f", level_f, 0);
    chk("rst_ne_f", ne_f, 0);
    chk("rst_ae_f", ae_f, 1);
    chk("rst_flags_f", {full_f, af_f, ovf_f, unf_f}, 0);
    chk("rst_rd_f", rd_f, 0);
    chk("rst_level_r", level_r, 0);
    chk("rst_ae_r", ae_r, 1);
    chk("rst_flags_r", {ne_r, full_r, af_r, ovf_r, unf_r}, 0);
    chk("rst_rd_r", rd_r, 0);

    // Flush: set unf, load 5 words, then clr with a write that must be ignored
    for (int pass = 0; pass < 2; pass++) begin
      re = 1'b1;
      step();
      re = 1'b0;
      chk("pre_unf", unf_f, 1);
      for (int i = 0; i < 5; i++) begin
        we = 1'b1; wr_data = 18'(i + 1);
        step();
      end
      chk("pre_level", level_f, 5);
      we = 1'b1; wr_data = 18'h3ffff;
      if (pass == 0) clr = 1'b1;
      else           reset_l = 1'b0;
      step();
      clr = 1'b0; reset_l = 1'b1; we = 1'b0;
      chk(pass == 0 ? "clr_level" : "rstl_level", level_f, 0);
      chk(pass == 0 ? "clr_ne" : "rstl_ne", ne_f, 0);
      chk(pass == 0 ? "clr_ae" : "rstl_ae", ae_f, 1);
      chk(pass == 0 ? "clr_ovf_unf" : "rstl_ovf_unf", {ovf_f, unf_f}, 0);
      chk(pass == 0 ? "clr_level_r" : "rstl_level_r", level_r, 0);
    end

    // FWFT latency: write at edge N, head visible after edge N+3
    we = 1'b1; wr_data = 18'h12345;
    step();
    we = 1'b0;
    chk("lat_level", level_f, 1);
    chk("lat_ne_n0", ne_f, 0);
    step();
    chk("lat_ne_n1", ne_f, 0);
    step();
    chk("lat_ne_n2", ne_f, 0);
    step();
    chk("lat_ne_n3", ne_f, 1);
    chk("lat_data", rd_f, 18'h12345);
    re = 1'b1;
    step();
    re = 1'b0;
    chk("lat_pop_ne", ne_f, 0);
    chk("lat_pop_level", level_f, 0);
    chk("lat_pop_unf", unf_f, 0);

    // Streaming: write every cycle, pop every cycle once the head appears
    do_reset();
    started = 0; rcnt = 0;
    for (int i = 0; i < 210; i++) begin
      we = 1'b1; wr_data = 18'(i); re = started;
      if (started) begin
        chk("stream_data", rd_f, 32'(rcnt));
        chk("stream_ne", ne_f, 1);
        chk("stream_level", level_f, 4);
        rcnt++;
      end
      step();
      if (ne_f) started = 1;
    end
    we = 1'b0; re = 1'b0;
    chk("stream_count", rcnt, 206);
    chk("stream_unf_ovf", {unf_f, ovf_f}, 0);

    // Fill to capacity, boundary simultaneous op, overflow, drain
    do_reset();
    af_thresh = 6'd20;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; wr_data = 18'(100 + i);
      step();
      chk("fill_level", level_f, 32'(i + 1));
      chk("fill_full", full_f, (i + 1) >= 28);
      chk("fill_af", af_f, (i + 1) >= 20);
    end
    chk("fill_ovf", ovf_f, 0);
    we = 1'b1; re = 1'b1; wr_data = 18'd132;
    chk("bnd_head", rd_f, 100);
    step();
    chk("bnd_level", level_f, 32);
    chk("bnd_ovf", ovf_f, 0);
    re = 1'b0; wr_data = 18'd999;
    step();
    we = 1'b0;
    chk("ovf_level", level_f, 32);
    chk("ovf_flag", ovf_f, 1);
    rcnt = 0;
    for (int i = 0; i < 200 && rcnt < 32; i++) begin
      re = ne_f;
      if (ne_f) begin
        chk("drain_data", rd_f, 32'(101 + rcnt));
        rcnt++;
      end
      step();
    end
    re = 1'b0;
    chk("drain_count", rcnt, 32);
    chk("drain_level", level_f, 0);
    chk("drain_ne", ne_f, 0);
    chk("drain_flags", {full_f, af_f, ae_f, unf_f}, 4'b0010);

    // Registered-read mode, table-driven with ae_thresh=3, af_thresh=5
    vecs[0]  = '{1'b0, 1'b1, 18'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 18'h0};
    vecs[1]  = '{1'b1, 1'b0, 18'hA, 1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h0};
    vecs[2]  = '{1'b1, 1'b0, 18'hB, 2, 1'b1, 1'b1, 1'b0, 1'b1, 18'h0};
    vecs[3]  = '{1'b1, 1'b0, 18'hC, 3, 1'b1, 1'b1, 1'b0, 1'b1, 18'h0};
    vecs[4]  = '{1'b1, 1'b0, 18'hD, 4, 1'b1, 1'b0, 1'b0, 1'b1, 18'h0};
    vecs[5]  = '{1'b1, 1'b0, 18'hE, 5, 1'b1, 1'b0, 1'b1, 1'b1, 18'h0};
    vecs[6]  = '{1'b0, 1'b1, 18'h0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 18'h0};
    vecs[7]  = '{1'b0, 1'b1, 18'h0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 18'hA};
    vecs[8]  = '{1'b1, 1'b1, 18'hF, 3, 1'b1, 1'b1, 1'b0, 1'b1, 18'hB};
    vecs[9]  = '{1'b0, 1'b1, 18'h0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 18'hC};
    vecs[10] = '{1'b0, 1'b0, 18'h0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 18'hD};
    do_reset();
    af_thresh = 6'd5;
    ae_thresh = 6'd3;
    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; re = vecs[i].re; wr_data = vecs[i].d;
      step();
      chk($sformatf("reg_level[%0d]", i), level_r, 32'(vecs[i].lvl));
      chk($sformatf("reg_ne[%0d]", i), ne_r, vecs[i].ne);
      chk($sformatf("reg_ae[%0d]", i), ae_r, vecs[i].ae);
      chk($sformatf("reg_af[%0d]", i), af_r, vecs[i].af);
      chk($sformatf("reg_unf[%0d]", i), unf_r, vecs[i].unf);
      chk($sformatf("reg_rd[%0d]", i), rd_r, vecs[i].rd);
    end
    we = 1'b0; re = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds an occupancy level output, run-time programmable almost-full/almost-empty thresholds, a synchronous flush, and a selectable read mode:
  - first-word-fall-through (zero-latency re to data), or
  - registered read.
- Sits between producer/consumer pipelines in the datapath.
- Storage is an inferred simple-dual-port RAM plus a 2-entry output prefetch stage.

Parameters:
- ADDRWIDTH, 5: capacity DEPTH = 2^ADDRWIDTH words.
- DATAWIDTH, 18: word width.
- SLOP, 4: fixed full threshold; full asserts at level >= DEPTH-SLOP.
- FWFT, 1: 1 = first-word-fall-through (rd_data valid whenever ne); 0 = registered read (rd_data valid the cycle after re).

Ports:
- clk  in  1  clock
- reset_l  in  1  synchronous active-low reset
- clr  in  1  synchronous flush
- wr_data  in  DATAWIDTH  write data
- we  in  1  write enable
- full  out  1  registered, level >= DEPTH-SLOP
- almost_full  out  1  registered, level >= af_thresh
- ovf  out  1  sticky overflow error
- rd_data  out  DATAWIDTH  read data
- re  in  1  read enable / pop
- ne  out  1  registered not-empty (head word presentable)
- almost_empty  out  1  registered, level <= ae_thresh
- unf  out  1  sticky underflow error
- level  out  ADDRWIDTH+1  words accepted and not yet popped
- af_thresh  in  ADDRWIDTH+1  almost-full threshold, quasi-static
- ae_thresh  in  ADDRWIDTH+1  almost-empty threshold, quasi-static

Behaviour:
- All state updates on posedge clk. reset_l=0 at an edge sets:
  - pointers, prefetch stage, level=0
  - ne=0, full=0, almost_full=0, ovf=0, unf=0, rd_data=0
  - almost_empty=1
- Reset mid-operation discards all contents, with no partial writes.
- clr=1 (reset_l=1): same effect as reset, including clearing ovf/unf. we/re in the same cycle are ignored.
- Capacity is DEPTH user words. The 2-entry prefetch stage is internal slack and never raises usable capacity.
- Write:
  - we with level<DEPTH, or level==DEPTH with a simultaneous valid pop: word accepted.
  - we with level==DEPTH and no pop: word dropped, ovf<=1 (sticky).
- Pop: valid only when ne=1. re with ne=0 is ignored and sets unf<=1 (sticky).
- level(next) = level + accepted_write - valid_pop. Never wraps. Simultaneous write+pop leaves level unchanged.
- full, almost_full and almost_empty are computed from level(next) and registered, so they are valid the same cycle level updates.
- FWFT=1:
  - Empty FIFO: write at edge N gives ne=1 and rd_data=word after edge N+3 (RAM registered read, then prefetch transfer).
  - While ne=1, rd_data is the head word. re at edge K presents the next word after edge K with no bubble, provided it is present in the prefetch stage.
  - RAM-to-prefetch transfer occurs whenever the prefetch stage has a free slot (counting the concurrent pop) and the RAM is non-empty. This sustains 1 word/cycle.
- FWFT=0:
  - ne=1 when level>0 (latency 1 after write).
  - re at edge K gives rd_data = popped word after edge K+1. rd_data holds between pops.
- level is allowed to be nonzero while ne=0 (words in flight in FWFT mode).
- Ordering is strict FIFO across RAM wrap-around. Pointers are ADDRWIDTH bits and wrap modulo DEPTH.
- Threshold inputs may change at any time; the flags reflect the new value after one edge.

Decomposition:
- Package fifo_pkg:
  - localparam-style constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1
  - function for level width (ADDRWIDTH+1)
  - shared with the existing FIFO family
- Sub-module fifo_ram_sdp:
  - DATAWIDTH x DEPTH simple-dual-port RAM with registered read, no reset on the array.
- Top handles pointers, level, flags, prefetch stage and mode muxing.

Test Plan:
- Reset/clr: fill 5 words, assert clr → next cycle level=0, ne=0, almost_empty=1, ovf=unf=0. Same check with reset_l.
- FWFT latency: ADDRWIDTH=5, FWFT=1, single write 0x12345 at edge N → ne=1 and rd_data=0x12345 after edge N+3. re for one cycle → ne=0, level=0.
- Streaming: continuous we and re (after the first word appears) of an incrementing pattern for 200 cycles → every word is read in order with no bubble. level is constant, ptr wrap-around is crossed 6 times.
- Fill/overflow: write 32 words with no reads → level=32. full=1 from level 28 (SLOP=4), almost_full=1 at af_thresh=20. 33rd write is dropped and ovf=1. Drain reads words 0..31 only.
- Boundary simultaneous ops: level=32 with we+re in the same cycle → write accepted, ovf stays 0, level stays 32.
- Underflow and registered mode: FWFT=0, re on empty → unf=1, level stays 0. Write 0xA then re at edge K → rd_data=0xA after edge K+1. ae_thresh=3 → almost_empty toggles exactly when crossing level 3/4.
